// File: rtl/reg_dump_reader_if.sv
//------------------------------------------------------------------------------
// Module   : reg_dump_reader_if
// Brief    : Control, bank-read and record-stream signals of the register dump reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              hold_wr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, hold_wr, out_valid, out_index, out_data, busy, done
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, hold_wr, out_valid, out_index, out_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/reg_dump_reader.sv
//------------------------------------------------------------------------------
// Module   : reg_dump_reader
// Brief    : Walks the register bank and streams {index, value} records while
//            holding off register writes so the snapshot stays consistent.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  reg_dump_reader_if.master   dump_io
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (dump_io.start) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        idx_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        out_index_d = idx_q;
        out_data_d  = dump_io.rd_data;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (dump_io.out_ready) begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything once a dump is running; no done pulse follows.
    if ((state_q != S_IDLE) && dump_io.abort) begin
      idx_d   = '0;
      state_d = S_IDLE;
    end
  end

  assign dump_io.rd_addr   = idx_q;
  assign dump_io.hold_wr   = (state_q == S_ARM) || (state_q == S_READ) || (state_q == S_SEND);
  assign dump_io.out_valid = (state_q == S_SEND);
  assign dump_io.out_index = out_index_q;
  assign dump_io.out_data  = out_data_q;
  assign dump_io.busy      = (state_q != S_IDLE);
  assign dump_io.done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_dump_reader
// Brief    : Directed bench with a timing-level record model for reg_dump_reader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_dump_reader;
  localparam int N      = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .dump_io (bus.master)
  );

  logic [DATA_W-1:0] bank [N];
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  assign bus.rd_data = bank[bus.rd_addr];

  always @(posedge clk) begin
    if (wr_en && !bus.hold_wr) bank[wr_addr] <= wr_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] preload(input int i);
    return (i == 29) ? 32'h0000_0FFC : DATA_W'(i * 32'h11);
  endfunction

  int cyc = 0;
  int rdy_mode = 0;
  int stall_idx = -1;

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rdy_mode == 1) bus.out_ready = (cyc % 3 == 0);
      else               bus.out_ready = (int'(bus.out_index) != stall_idx);
    end
  end

  // Model: a dump is a sequence of N records; the first appears 2 cycles after
  // the start cycle, each later one 1 cycle after the previous is accepted.
  bit m_in = 0, m_done = 0;
  int m_cd = 0, m_rec = 0;
  int acc_cnt = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = -1;
  logic [DATA_W-1:0] rec29_data = '0;

  always @(negedge clk) begin
    bit ev;
    if (!reset) begin
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_hold",  bus.hold_wr,   0);
      chk("rst_busy",  bus.busy,      0);
      chk("rst_done",  bus.done,      0);
      m_in = 0; m_done = 0; m_cd = 0; m_rec = 0;
    end else begin
      ev = m_in && !m_done && (m_cd == 0);
      chk("busy",    bus.busy,      m_in);
      chk("hold_wr", bus.hold_wr,   m_in && !m_done);
      chk("valid",   bus.out_valid, ev);
      chk("done",    bus.done,      m_done);
      chk("rd_addr", bus.rd_addr,   m_in ? m_rec : 0);
      if (ev) begin
        chk("index", bus.out_index, m_rec);
        chk("data",  bus.out_data,  preload(m_rec));
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!m_in) begin
        if (bus.start) begin
          m_in = 1; m_cd = 2; m_rec = 0; acc_cnt = 0; first_valid_cyc = -1;
        end
      end else if (bus.abort) begin
        m_in = 0; m_done = 0;
      end else if (m_done) begin
        m_in = 0; m_done = 0;
      end else if (m_cd > 0) begin
        m_cd--;
      end else if (bus.out_ready) begin
        acc_cnt++;
        if (m_rec == 29) rec29_data = bus.out_data;
        if (m_rec == N - 1) m_done = 1;
        else begin m_rec++; m_cd = 1; end
      end
    end
  end

  task automatic pulse_start(output int c0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_rec(input int idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && int'(bus.out_index) == idx) && n < 400);
    if (n >= 400) chk("wait_rec_timeout", 1, 0);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("wait_done_timeout", 1, 0);
  endtask

  int s0;
  int d_before;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < N; i++) bank[i] = preload(i);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // 1: free-flowing dump
    rdy_mode = 0; stall_idx = -1;
    pulse_start(s0);
    wait_done();
    chk("t1_first_valid_lat", first_valid_cyc - s0, 3);
    chk("t1_done_cycle", done_cyc - s0, 66);
    chk("t1_records", acc_cnt, 32);
    chk("t1_rec29", rec29_data, 32'h0000_0FFC);

    // 2: consumer ready one cycle in three
    rdy_mode = 1;
    pulse_start(s0);
    wait_done();
    chk("t2_records", acc_cnt, 32);
    chk("t2_done_delayed", (done_cyc - s0) > 66, 1);
    rdy_mode = 0;

    // 3: writes attempted during the dump are gated
    pulse_start(s0);
    wait_rec(2);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_DEAD;
    wait_rec(20);
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_done();
    chk("t3_records", acc_cnt, 32);
    chk("t3_bank5_kept", bank[5], 32'h55);

    // 4: abort while index 10 is stalled
    stall_idx = 10;
    pulse_start(s0);
    wait_rec(10);
    d_before = done_cnt;
    @(posedge clk); #1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    #3;
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_hold",  bus.hold_wr,   0);
    chk("t4_busy",  bus.busy,      0);
    repeat (4) @(negedge clk);
    chk("t4_no_done", done_cnt, d_before);
    stall_idx = -1;
    pulse_start(s0);
    wait_done();
    chk("t4_restart_records", acc_cnt, 32);

    // 5: start pulse mid-dump is ignored
    pulse_start(s0);
    wait_rec(3);
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_done();
    chk("t5_records", acc_cnt, 32);
    chk("t5_done_cycle", done_cyc - s0, 66);

    // 6: asynchronous reset mid-record
    stall_idx = 7;
    pulse_start(s0);
    wait_rec(7);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_hold",  bus.hold_wr,   0);
    chk("t6_busy",  bus.busy,      0);
    chk("t6_addr",  bus.rd_addr,   0);
    chk("t6_index", bus.out_index, 0);
    chk("t6_data",  bus.out_data,  0);
    @(posedge clk); #2;
    reset = 1'b1;
    stall_idx = -1;
    repeat (2) @(posedge clk);
    pulse_start(s0);
    wait_done();
    chk("t6_records", acc_cnt, 32);
    chk("t6_done_cycle", done_cyc - s0, 66);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
